ram_arbiter: RTL and testbench

- Shares the single-port synchronous RAM between two requesters: the CPU memory port (requester 0) and a program loader / DMA port (requester 1).
- Each cycle it grants at most one requester, muxes that requester's address, write-enable and data onto the RAM, and routes the read data back one cycle later.
- After reset it runs a boot phase. In this phase only the loader may access RAM and the CPU is held.
- Sits between the CPU core and the RAM instance at top level.

---
 rtl/ram_arbiter.sv | 113 +++++++++++
 tb/tb_ram_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between CPU and loader with boot phase
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter bit BOOT_HOLD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    input  logic                  ldr_done,
    output logic                  ldr_gnt,
    output logic                  ldr_rvalid,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   boot_words,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} phase_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;

    localparam logic [ADDR_WIDTH:0] BOOT_MAX = '1;
    localparam logic [ADDR_WIDTH:0] BOOT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    phase_t                phase, phase_nxt;
    owner_t                last_owner, owner_nxt;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [DATA_WIDTH-1:0] wdata_hold;

    always_comb begin
        phase_nxt = phase;
        owner_nxt = last_owner;
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        case (phase)
            BOOT: begin
                ldr_gnt = ldr_req;
                if (ldr_done) phase_nxt = RUN;
            end
            RUN: begin
                if (cpu_req && ldr_req) begin
                    // Tie goes to whoever did not own the RAM last.
                    if (last_owner == OWN_CPU) ldr_gnt = 1'b1;
                    else                       cpu_gnt = 1'b1;
                end else begin
                    cpu_gnt = cpu_req;
                    ldr_gnt = ldr_req;
                end
            end
            default: phase_nxt = RUN;
        endcase
        if (cpu_gnt)      owner_nxt = OWN_CPU;
        else if (ldr_gnt) owner_nxt = OWN_LDR;
    end

    // Idle cycles keep the last address/data on the bus so the RAM never sees a glitch.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_hold;
        ram_wdata = wdata_hold;
        if (cpu_gnt) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (ldr_gnt) begin
            ram_we    = ldr_we;
            ram_addr  = ldr_addr;
            ram_wdata = ldr_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_gnt || ldr_gnt) begin
            addr_hold  <= ram_addr;
            wdata_hold <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase      <= BOOT_HOLD ? BOOT : RUN;
            last_owner <= OWN_LDR;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            boot_words <= '0;
        end else begin
            phase      <= phase_nxt;
            last_owner <= owner_nxt;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            ldr_rvalid <= ldr_gnt && !ldr_we;
            if (phase == BOOT && ldr_gnt && ldr_we && boot_words != BOOT_MAX)
                boot_words <= boot_words + BOOT_ONE;
        end
    end

    assign cpu_hold  = (phase == BOOT);
    assign cpu_rdata = ram_rdata;
    assign ldr_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter against a behavioural model
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_done;
    logic [3:0] cpu_addr, ldr_addr;
    logic [7:0] cpu_wdata, ldr_wdata;
    logic       cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, cpu_hold, ram_we;
    logic [7:0] cpu_rdata, ldr_rdata, ram_wdata, ram_rdata;
    logic [3:0] ram_addr;
    logic [4:0] boot_words;

    logic       b_reset, b_cpu_req, b_cpu_we, b_ldr_req, b_ldr_we, b_ldr_done;
    logic [3:0] b_cpu_addr, b_ldr_addr, b_ram_addr;
    logic [7:0] b_cpu_wdata, b_ldr_wdata, b_ram_rdata, b_cpu_rdata, b_ldr_rdata, b_ram_wdata;
    logic       b_cpu_gnt, b_cpu_rvalid, b_ldr_gnt, b_ldr_rvalid, b_cpu_hold, b_ram_we;
    logic [4:0] b_boot_words;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .BOOT_HOLD(1'b1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_done(ldr_done), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .cpu_hold(cpu_hold), .boot_words(boot_words),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .BOOT_HOLD(1'b0)) dut_run (
        .clk(clk), .reset(b_reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
        .ldr_done(b_ldr_done), .ldr_gnt(b_ldr_gnt), .ldr_rvalid(b_ldr_rvalid), .ldr_rdata(b_ldr_rdata),
        .cpu_hold(b_cpu_hold), .boot_words(b_boot_words),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // Synchronous single-port RAM behind the main instance.
    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Reference model state
    bit         m_boot, m_last_cpu, m_hold_ok;
    int         m_bw;
    logic [7:0] m_mem [16];
    logic [3:0] m_addr;
    logic [7:0] m_wdata;
    bit         last_g_cpu, last_g_ldr;

    typedef struct { int due; bit who_cpu; logic [7:0] data; } exp_t;
    exp_t q[$];

    task automatic model_reset();
        m_boot     = 1'b1;
        m_last_cpu = 1'b0;
        m_bw       = 0;
        m_hold_ok  = 1'b0;
    endtask

    task automatic step();
        logic       gc, gl, w;
        logic [3:0] a;
        logic [7:0] d;
        @(negedge clk);
        if (m_boot) begin
            gc = 1'b0; gl = ldr_req;
        end else if (cpu_req && ldr_req) begin
            gc = !m_last_cpu; gl = m_last_cpu;
        end else begin
            gc = cpu_req; gl = ldr_req;
        end
        w = gc ? cpu_we    : (gl ? ldr_we    : 1'b0);
        a = gc ? cpu_addr  : (gl ? ldr_addr  : m_addr);
        d = gc ? cpu_wdata : (gl ? ldr_wdata : m_wdata);
        chk("cpu_gnt", cpu_gnt, gc);
        chk("ldr_gnt", ldr_gnt, gl);
        chk("cpu_hold", cpu_hold, m_boot);
        chk("boot_words", boot_words, m_bw);
        chk("ram_we", ram_we, w);
        if (gc || gl || m_hold_ok) begin
            chk("ram_addr", ram_addr, a);
            chk("ram_wdata", ram_wdata, d);
        end
        if ((gc || gl) && w) m_mem[a] = d;
        if (gc || gl) begin
            m_addr = a; m_wdata = d; m_hold_ok = 1'b1;
        end
        if (!reset) begin
            model_reset();
        end else begin
            if ((gc || gl) && !w) q.push_back('{cyc + 1, gc, m_mem[a]});
            if (m_boot && gl && ldr_we && m_bw < 31) m_bw++;
            if (gc)      m_last_cpu = 1'b1;
            else if (gl) m_last_cpu = 1'b0;
            if (m_boot && ldr_done) m_boot = 1'b0;
        end
        last_g_cpu = gc;
        last_g_ldr = gl;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rvalid must match the oldest pending read.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_rvalid || ldr_rvalid) begin
            if (q.size() == 0) begin
                chk("rvalid_unexpected", {30'd0, cpu_rvalid, ldr_rvalid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rvalid_cycle", cyc, e.due);
                chk("rvalid_who", {30'd0, cpu_rvalid, ldr_rvalid}, e.who_cpu ? 32'd2 : 32'd1);
                chk("rdata", e.who_cpu ? cpu_rdata : ldr_rdata, e.data);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("rvalid_missing", {30'd0, cpu_rvalid, ldr_rvalid}, e.who_cpu ? 32'd2 : 32'd1);
        end
    end

    task automatic set_cpu(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ldr(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        ldr_req = r; ldr_we = w; ldr_addr = a; ldr_wdata = d;
    endtask

    logic [3:0] boot_a [3];
    logic [7:0] boot_d [3];

    initial begin
        boot_a[0] = 4'd0;  boot_d[0] = 8'hA5;
        boot_a[1] = 4'd1;  boot_d[1] = 8'h3C;
        boot_a[2] = 4'd15; boot_d[2] = 8'hFF;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_addr = '0; m_wdata = '0;
        reset = 1'b0; ldr_done = 1'b0;
        set_cpu(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
        b_reset = 1'b0; b_ldr_done = 1'b0; b_ram_rdata = 8'h00;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_ldr_req = 0; b_ldr_we = 0; b_ldr_addr = 0; b_ldr_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Boot image load while the CPU keeps requesting
        set_cpu(1, 0, 4'd5, 8'h00);
        for (int i = 0; i < 3; i++) begin
            set_ldr(1, 1, boot_a[i], boot_d[i]);
            step();
        end
        set_ldr(0, 0, 0, 0);
        ldr_done = 1'b1;
        step();
        ldr_done = 1'b0;
        set_cpu(1, 0, 4'd1, 8'h00);
        step();
        chk("boot_cpu_read_model", m_mem[1], 8'h3C);

        // Loader takes one access so the following tie starts with the CPU
        set_cpu(0, 0, 0, 0);
        set_ldr(1, 0, 4'd15, 8'h00);
        step();
        set_cpu(1, 0, 4'd0, 8'h00);
        set_ldr(1, 0, 4'd15, 8'h00);
        repeat (6) step();

        // Write then read-after-write from the other requester
        set_ldr(0, 0, 0, 0);
        set_cpu(1, 1, 4'd2, 8'h11);
        step();
        set_cpu(0, 0, 0, 0);
        set_ldr(1, 0, 4'd2, 8'h00);
        step();
        set_ldr(0, 0, 0, 0);
        step();

        // Randomized RUN traffic; requesters hold their request until granted
        for (int i = 0; i < 300; i++) begin
            if (!cpu_req || last_g_cpu)
                set_cpu($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 8'($urandom));
            if (!ldr_req || last_g_ldr)
                set_ldr($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 8'($urandom));
            ldr_done = ($urandom_range(0, 15) == 0);
            step();
        end
        ldr_done = 1'b0;
        set_cpu(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
        repeat (2) step();

        // Reset lands on the edge that would launch the CPU read data
        set_cpu(1, 0, 4'd7, 8'h00);
        reset = 1'b0;
        step();
        set_cpu(0, 0, 0, 0);
        step();
        reset = 1'b1;
        step();

        // Long boot load pushes boot_words into saturation
        set_cpu(1, 0, 4'd3, 8'h00);
        for (int i = 0; i < 35; i++) begin
            set_ldr(1, 1, 4'($urandom_range(0, 15)), 8'($urandom));
            step();
        end
        chk("boot_words_saturated", boot_words, 5'd31);
        set_ldr(0, 0, 0, 0);
        ldr_done = 1'b1;
        step();
        ldr_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_cpu(1, 0, 4'(i), 8'h00);
            step();
        end
        set_cpu(0, 0, 0, 0);
        repeat (3) step();
        chk("scoreboard_drained", q.size(), 0);

        // Instance that starts directly in RUN
        @(posedge clk); #1;
        b_reset = 1'b1;
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 4'd3;
        @(negedge clk);
        chk("run_cpu_hold", b_cpu_hold, 1'b0);
        chk("run_cpu_gnt_first", b_cpu_gnt, 1'b1);
        @(posedge clk); #1;
        b_cpu_req = 1'b0;
        b_ldr_req = 1'b1; b_ldr_we = 1'b1; b_ldr_addr = 4'd4; b_ldr_wdata = 8'h5A;
        b_ldr_done = 1'b1;
        @(negedge clk);
        chk("run_cpu_rvalid", b_cpu_rvalid, 1'b1);
        chk("run_ldr_gnt", b_ldr_gnt, 1'b1);
        @(posedge clk); #1;
        b_ldr_done = 1'b0;
        b_cpu_req = 1'b1;
        b_ldr_we = 1'b0;
        @(negedge clk);
        chk("run_boot_words", b_boot_words, 5'd0);
        chk("run_hold_after_done", b_cpu_hold, 1'b0);
        chk("run_tie_cpu", b_cpu_gnt, 1'b1);
        chk("run_tie_ldr", b_ldr_gnt, 1'b0);
        @(posedge clk); #1;
        b_cpu_req = 1'b0; b_ldr_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
